fp_mul_scheduler: RTL

FP_MUL_SCHEDULER -- requirements
Module: fp_mul_scheduler

---
 rtl/fp_mul_scheduler.sv | 80 ++++++++
 1 files changed

// File: rtl/fp_mul_scheduler.sv
// fp_mul_scheduler: round-robin arbiter sharing one combinational float multiplier between two requesters
module fp_mul_scheduler #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [15:0] op_count
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_ptr, r_id;
  logic [3:0]  r_cnt;
  logic [31:0] r_mul_a, r_mul_b, r_rsp;
  logic [15:0] r_op_count;
  logic        w_acc, w_gnt, w_hs;
  always_comb begin
    w_acc  = (r_state == IDLE) && (req0_valid || req1_valid);
    w_gnt  = (req0_valid && req1_valid) ? r_ptr : req1_valid;
    w_hs   = (r_state == RESP) && (r_id ? rsp1_ready : rsp0_ready);
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? WAIT : IDLE;
      WAIT:    w_next = (r_cnt == 4'd1) ? RESP : WAIT;
      RESP:    w_next = w_hs ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_id       <= 1'b0;
      r_cnt      <= 4'd0;
      r_mul_a    <= 32'd0;
      r_mul_b    <= 32'd0;
      r_rsp      <= 32'd0;
      r_op_count <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_mul_a <= w_gnt ? req1_a : req0_a;
        r_mul_b <= w_gnt ? req1_b : req0_b;
        r_id    <= w_gnt;
        r_cnt   <= 4'(MUL_LATENCY);
        r_ptr   <= !w_gnt;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) r_rsp <= mul_result;
      end
      if (w_hs) r_op_count <= r_op_count + 16'd1;
    end
  end
  // handshake outputs are forced low while reset is held, even before the reset edge
  assign req0_ready = !rst && w_acc && !w_gnt;
  assign req1_ready = !rst && w_acc && w_gnt;
  assign rsp0_valid = !rst && (r_state == RESP) && !r_id;
  assign rsp1_valid = !rst && (r_state == RESP) && r_id;
  assign busy       = !rst && (r_state != IDLE);
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign rsp_data   = r_rsp;
  assign op_count   = r_op_count;
endmodule
